// File: rtl/arm_chk_pkg.sv
// ---------------------------------------------------------------------------
// arm_chk_pkg
// Shared types and constants for arm_write_checker.
//   state_e   : checker states (IDLE, RUN, PASS, FAIL)
//   FC_*      : fail_code encodings
//   entry_t   : one expected store {addr, data} at the default 32/32 widths;
//               the parametrised table declares a width-matched copy.
// ---------------------------------------------------------------------------
package arm_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ADDR    = 2'b01;
    localparam logic [1:0] FC_DATA    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_DATA_W = 32;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/arm_chk_table.sv
// ---------------------------------------------------------------------------
// arm_chk_table
// DEPTH-entry table of expected stores: one synchronous write port, one
// asynchronous read port.
//   clk        : write clock
//   wr_en_i    : write strobe (caller guarantees wr_idx_i < DEPTH)
//   wr_idx_i   : entry to write
//   wr_addr_i  : expected address to store
//   wr_data_i  : expected data to store
//   rd_idx_i   : entry to read
//   rd_addr_o  : expected address of entry rd_idx_i
//   rd_data_o  : expected data of entry rd_idx_i
// ---------------------------------------------------------------------------
module arm_chk_table
    import arm_chk_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } row_t;

    row_t mem_q [DEPTH];

    // NOTE: the table has no reset branch on purpose: a reset must keep the
    // loaded expectations so a board can re-run the self-test without reloading,
    // and leaving the array out of reset lets it map onto plain storage.
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= '{addr: wr_addr_i, data: wr_data_i};
        end
    end

    assign rd_addr_o = mem_q[rd_idx_i].addr;
    assign rd_data_o = mem_q[rd_idx_i].data;

endmodule

// File: rtl/arm_write_checker.sv
// ---------------------------------------------------------------------------
// arm_write_checker
// Snoops the ARM core data-memory write port and checks every store, in
// order, against a loadable table of expected (address, data) pairs.
//
// Build option: define ARM_CHK_FILTER_EN to ignore stores whose address does
// not match the current entry (legacy "skip other addresses" behaviour); with
// it undefined every store must match the next entry exactly.
//
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   load_en/idx/addr/data : table write, accepted only in IDLE
//   num_checks            : entries used by the run (0 or >DEPTH -> DEPTH)
//   start                 : IDLE/PASS/FAIL -> RUN
//   MemWrite/ALUResult/WriteData : snooped core store port
//   busy, done, pass      : status
//   fail_code, fail_idx   : fail reason and table index at failure
//   cycle_cnt             : cycles spent in RUN, saturating
// ---------------------------------------------------------------------------
module arm_write_checker
    import arm_chk_pkg::*;
#(
    parameter int  DATA_W      = 32,
    parameter int  ADDR_W      = 32,
    parameter int  DEPTH       = 4,
    parameter int  TIMEOUT_CYC = 1000,
    localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  num_checks,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [31:0]       cycle_cnt
);

    // Timeout counter only ever holds 0..TIMEOUT_CYC-1.
    localparam int               TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] DEPTH_N  = CNT_W'(DEPTH);
    localparam logic [IDX_W:0]   DEPTH_I  = (IDX_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]  n_q,     n_d;
    logic [31:0]       cyc_q,   cyc_d;
    logic [TMO_W-1:0]  tmo_q,   tmo_d;
    logic [1:0]        fc_q,    fc_d;
    logic [IDX_W-1:0]  fidx_q,  fidx_d;

    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              tbl_we;
    logic [CNT_W-1:0]  n_start;
    logic              is_last;
    logic              term;

    // Reset blocks the table write too, so a load during reset never lands.
    assign tbl_we = reset && (state_q == ST_IDLE) && load_en
                    && ({1'b0, load_idx} < DEPTH_I);

    arm_chk_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk       (clk),
        .wr_en_i   (tbl_we),
        .wr_idx_i  (load_idx),
        .wr_addr_i (load_addr),
        .wr_data_i (load_data),
        .rd_idx_i  (idx_q),
        .rd_addr_o (exp_addr),
        .rd_data_o (exp_data)
    );

    assign n_start = (num_checks == '0 || num_checks > DEPTH_N) ? DEPTH_N : num_checks;
    assign is_last = (CNT_W'(idx_q) + CNT_W'(1)) == n_q;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        cyc_d   = cyc_q;
        tmo_d   = tmo_q;
        fc_d    = fc_q;
        fidx_d  = fidx_q;
        term    = 1'b0;

        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    n_d     = n_start;
                    cyc_d   = '0;
                    tmo_d   = '0;
                    fc_d    = FC_NONE;
                    fidx_d  = '0;
                end
            end
            ST_RUN: begin
                cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
                tmo_d = tmo_q + TMO_W'(1);
                if (MemWrite) begin
                    if (ALUResult != exp_addr) begin
`ifndef ARM_CHK_FILTER_EN
                        term    = 1'b1;
                        state_d = ST_FAIL;
                        fc_d    = FC_ADDR;
                        fidx_d  = idx_q;
`endif
                    end else if (WriteData != exp_data) begin
                        term    = 1'b1;
                        state_d = ST_FAIL;
                        fc_d    = FC_DATA;
                        fidx_d  = idx_q;
                    end else if (is_last) begin
                        term    = 1'b1;
                        state_d = ST_PASS;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                // A compare verdict in the same cycle outranks the timeout.
                if (!term && tmo_q == TMO_LAST) begin
                    state_d = ST_FAIL;
                    fc_d    = FC_TIMEOUT;
                    fidx_d  = idx_q;
                    idx_d   = idx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            cyc_q   <= '0;
            tmo_q   <= '0;
            fc_q    <= FC_NONE;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            cyc_q   <= cyc_d;
            tmo_q   <= tmo_d;
            fc_q    <= fc_d;
            fidx_q  <= fidx_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass      = (state_q == ST_PASS);
    assign fail_code = fc_q;
    assign fail_idx  = fidx_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: doc/arm_write_checker.md
Name: arm_write_checker

Overview:
- Synthesizable, parametrised successor to the processor bench's hand-coded "write 7 to address 100" check.
- Sits beside the ARM core and snoops its data-memory write port (MemWrite, ALUResult, WriteData).
- Compares every store, in order, against a loadable table of up to DEPTH expected (address, data) pairs.
- Reports pass, fail, fail reason and fail index, with a cycle-count timeout, for simulation and on-board self-test.

Parameters:
- DATA_W, 32, width of the snooped write data and of table data entries.
- ADDR_W, 32, width of the snooped address (ALUResult) and of table address entries.
- DEPTH, 4, number of table entries; must be >= 1.
- TIMEOUT_CYC, 1000, cycles allowed in RUN before fail; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low.
- load_en  in  1  table write strobe; accepted only in IDLE.
- load_idx  in  $clog2(DEPTH) (minimum 1)  table entry index for load_en.
- load_addr  in  ADDR_W  expected store address.
- load_data  in  DATA_W  expected store data.
- num_checks  in  $clog2(DEPTH+1)  number of entries used (1..DEPTH); sampled on start.
- start  in  1  one-cycle pulse: IDLE -> RUN.
- MemWrite  in  1  core store strobe.
- ALUResult  in  ADDR_W  core store address.
- WriteData  in  DATA_W  core store data.
- busy  out  1  high in RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS only.
- fail_code  out  2  00 none, 01 address mismatch, 10 data mismatch, 11 timeout.
- fail_idx  out  $clog2(DEPTH) (minimum 1)  table index being checked when fail occurred.
- cycle_cnt  out  32  cycles spent in RUN; saturates at all-ones.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state IDLE; all outputs 0; check index 0; timeout counter 0.
  - Table contents are not cleared.
  - Reset wins over every other input, including mid-RUN.
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - load_en writes entry load_idx; indexes >= DEPTH are ignored.
  - start latches num_checks (0 or >DEPTH is clamped to DEPTH), clears idx, cycle_cnt and the timeout counter, then -> RUN.
  - load_en and start in the same cycle: the load completes and the run starts; the loaded entry is visible to the first compare.
- RUN:
  - busy=1; cycle_cnt increments every cycle.
  - Each cycle with MemWrite=1, compare ALUResult/WriteData against entry idx, registered with one-cycle latency to the outputs:
    - address differs -> FAIL, code 01.
    - address matches, data differs -> FAIL, code 10.
    - both match and idx = n-1 -> PASS.
    - both match otherwise -> idx++.
  - Timeout counter reaches TIMEOUT_CYC-1 with no terminal event that cycle -> FAIL, code 11.
  - A compare result on the same cycle as the timeout takes priority over the timeout.
  - MemWrite held for consecutive cycles counts as one store per cycle.
  - load_en and start are ignored.
- PASS / FAIL:
  - Sticky; done=1, busy=0; outputs hold.
  - start -> RUN with a fresh run (table retained).
  - load_en is ignored; it is accepted only in IDLE.
- All compares are full-width equality; no don't-care bits.

Optional Feature:
- Macro: ARM_CHK_FILTER_EN.
- Defined: in RUN, a store whose address differs from entry idx is ignored (no fail, idx unchanged); fail_code 01 is never produced. This matches the legacy "skip writes to other addresses" behaviour.
- Undefined: strict in-order checking exactly as described in Behaviour.

Decomposition:
- Package arm_chk_pkg holds:
  - state enum (IDLE, RUN, PASS, FAIL).
  - fail_code constants (FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT).
  - entry struct {addr, data}.
- One natural sub-module, arm_chk_table: DEPTH-entry register file with one write port and one asynchronous read port indexed by idx.

Test Plan:
- Legacy case:
  - load entry0 (96, x), entry1 (100, 7), n=2, start.
  - Stores (96, x) then (100, 7) -> pass=1, done=1, fail_code=00 one cycle after the second store.
- Data mismatch: same table; stores (96, x), (100, 8) -> fail_code=10, fail_idx=1, pass=0.
- Address mismatch: first store (104, 3) -> fail_code=01, fail_idx=0. With ARM_CHK_FILTER_EN, the same store is ignored and the run stays busy.
- Timeout: TIMEOUT_CYC=16, n=1, no stores -> fail_code=11 after exactly 16 RUN cycles; cycle_cnt=16.
- Reset mid-RUN:
  - Assert reset=0 during RUN -> next edge: IDLE, all outputs 0.
  - start again with the old table -> legacy sequence passes, confirming the table is retained.
- Boundaries:
  - num_checks=0 -> clamped to DEPTH.
  - start during PASS -> fresh run, cycle_cnt restarts at 0.
